// File: rtl/sccb_target_model.sv
// SCCB target model: answers 3-phase write and 2-phase read cycles with
// 16-bit sub-addresses, a small RW register window and fixed chip-ID bytes.
// Every accepted data byte of a write is reported on the reg_wr_* strobe.
module sccb_target_model #(
    parameter logic [7:0]  DEVICE_ADDR = 8'h78,
    parameter logic [15:0] REG_BASE    = 16'h3100,
    parameter int unsigned REG_AW      = 4,
    parameter logic [7:0]  ID_HI       = 8'h56,
    parameter logic [7:0]  ID_LO       = 8'h40
) (
    input  logic        clk,
    input  logic        rest_n,
    input  logic        sccb_scl,
    inout  wire         sccb_sda,
    output logic        reg_wr_valid,
    output logic [15:0] reg_wr_addr,
    output logic [7:0]  reg_wr_data,
    output logic        busy
);

    localparam int unsigned WIN = 2 ** REG_AW;

    typedef enum logic [3:0] {
        ST_IDLE, ST_DEV, ST_ACK_DEV, ST_SUB_HI, ST_ACK_HI, ST_SUB_LO,
        ST_ACK_LO, ST_WDATA, ST_ACK_W, ST_RDATA, ST_MACK, ST_WAIT_STOP
    } state_t;

    state_t      state, state_nxt;
    logic [2:0]  scl_sync, sda_sync;
    logic [3:0]  bit_cnt;
    logic [7:0]  shreg, tx;
    logic [15:0] ptr, ptr_inc;
    logic        sda_oe, mack_bit;
    logic [7:0]  mem [WIN];
    logic [7:0]  rd_cur, rd_next, rx_byte;
    logic        scl_now, scl_prev, sda_now, sda_prev;
    logic        scl_rise, scl_fall, start_det, stop_det;
    logic        rx_done, addr_match, in_window, wr_fire;

    function automatic logic [7:0] map_read(input logic [15:0] a);
        logic [7:0] v;
        v = 8'h00;
        if (a[15:REG_AW] == REG_BASE[15:REG_AW]) v = mem[a[REG_AW-1:0]];
        else if (a == 16'h300A)                  v = ID_HI;
        else if (a == 16'h300B)                  v = ID_LO;
        return v;
    endfunction

    assign sccb_sda   = sda_oe ? 1'b0 : 1'bz;
    assign busy       = (state != ST_IDLE);

    assign scl_now    = scl_sync[1];
    assign scl_prev   = scl_sync[2];
    assign sda_now    = sda_sync[1];
    assign sda_prev   = sda_sync[2];
    assign scl_rise   = scl_now & ~scl_prev;
    assign scl_fall   = ~scl_now & scl_prev;
    assign start_det  = scl_now & scl_prev & sda_prev & ~sda_now;
    assign stop_det   = scl_now & scl_prev & ~sda_prev & sda_now;

    assign rx_done    = (bit_cnt == 4'd8);
    assign rx_byte    = {shreg[6:0], sda_now};
    assign addr_match = (shreg[7:1] == DEVICE_ADDR[7:1]);
    assign ptr_inc    = ptr + 16'd1;
    assign in_window  = (ptr[15:REG_AW] == REG_BASE[15:REG_AW]);
    assign rd_cur     = map_read(ptr);
    assign rd_next    = map_read(ptr_inc);
    assign wr_fire    = scl_rise && (state == ST_WDATA) && (bit_cnt == 4'd7);

    // Bus synchronisers plus one history stage; idle bus level is high.
    always_ff @(posedge clk or negedge rest_n) begin
        if (!rest_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
        end else begin
            scl_sync <= {scl_sync[1:0], sccb_scl};
            sda_sync <= {sda_sync[1:0], sccb_sda};
        end
    end

    // Protocol state register.
    always_ff @(posedge clk or negedge rest_n) begin
        if (!rest_n) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    // Next state: START/STOP win in any state, otherwise phases advance on scl fall.
    always_comb begin
        state_nxt = state;
        if (start_det) begin
            state_nxt = ST_DEV;
        end else if (stop_det) begin
            state_nxt = ST_IDLE;
        end else if (scl_fall) begin
            case (state)
                ST_DEV:     if (rx_done) state_nxt = addr_match ? ST_ACK_DEV : ST_WAIT_STOP;
                ST_ACK_DEV: state_nxt = shreg[0] ? ST_RDATA : ST_SUB_HI;
                ST_SUB_HI:  if (rx_done) state_nxt = ST_ACK_HI;
                ST_ACK_HI:  state_nxt = ST_SUB_LO;
                ST_SUB_LO:  if (rx_done) state_nxt = ST_ACK_LO;
                ST_ACK_LO:  state_nxt = ST_WDATA;
                ST_WDATA:   if (rx_done) state_nxt = ST_ACK_W;
                ST_ACK_W:   state_nxt = ST_WDATA;
                ST_RDATA:   if (rx_done) state_nxt = ST_MACK;
                ST_MACK:    state_nxt = mack_bit ? ST_WAIT_STOP : ST_RDATA;
                default:    state_nxt = state;
            endcase
        end
    end

    // Datapath: shift in on scl rise, drive sda / load pointer on scl fall.
    always_ff @(posedge clk or negedge rest_n) begin
        if (!rest_n) begin
            bit_cnt      <= '0;
            shreg        <= '0;
            tx           <= '0;
            ptr          <= '0;
            sda_oe       <= 1'b0;
            mack_bit     <= 1'b1;
            reg_wr_valid <= 1'b0;
            reg_wr_addr  <= '0;
            reg_wr_data  <= '0;
        end else begin
            reg_wr_valid <= 1'b0;
            if (start_det || stop_det) begin
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
            end else if (scl_rise) begin
                case (state)
                    ST_DEV, ST_SUB_HI, ST_SUB_LO, ST_WDATA:
                        if (!rx_done) begin
                            shreg   <= rx_byte;
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    ST_RDATA: if (!rx_done) bit_cnt <= bit_cnt + 4'd1;
                    ST_MACK:  mack_bit <= sda_now;
                    default:  ;
                endcase
                if (wr_fire) begin
                    reg_wr_valid <= 1'b1;
                    reg_wr_addr  <= ptr;
                    reg_wr_data  <= rx_byte;
                    ptr          <= ptr_inc;
                end
            end else if (scl_fall) begin
                case (state)
                    ST_DEV:
                        if (rx_done) begin
                            bit_cnt <= '0;
                            sda_oe  <= addr_match;
                        end
                    ST_SUB_HI:
                        if (rx_done) begin
                            bit_cnt    <= '0;
                            sda_oe     <= 1'b1;
                            ptr[15:8]  <= shreg;
                        end
                    ST_SUB_LO:
                        if (rx_done) begin
                            bit_cnt   <= '0;
                            sda_oe    <= 1'b1;
                            ptr[7:0]  <= shreg;
                        end
                    ST_WDATA:
                        if (rx_done) begin
                            bit_cnt <= '0;
                            sda_oe  <= 1'b1;
                        end
                    ST_ACK_DEV: begin
                        bit_cnt <= '0;
                        if (shreg[0]) begin
                            tx     <= rd_cur;
                            sda_oe <= ~rd_cur[7];
                        end else begin
                            sda_oe <= 1'b0;
                        end
                    end
                    ST_ACK_HI, ST_ACK_LO, ST_ACK_W: begin
                        bit_cnt <= '0;
                        sda_oe  <= 1'b0;
                    end
                    ST_RDATA:
                        if (rx_done) begin
                            bit_cnt <= '0;
                            sda_oe  <= 1'b0;
                        end else begin
                            tx     <= {tx[6:0], 1'b0};
                            sda_oe <= ~tx[6];
                        end
                    ST_MACK: begin
                        bit_cnt <= '0;
                        if (!mack_bit) begin
                            ptr    <= ptr_inc;
                            tx     <= rd_next;
                            sda_oe <= ~rd_next[7];
                        end else begin
                            sda_oe <= 1'b0;
                        end
                    end
                    default: sda_oe <= 1'b0;
                endcase
            end
        end
    end

    // Register window storage; writes outside the window are reported only.
    always_ff @(posedge clk or negedge rest_n) begin
        if (!rest_n) begin
            for (int unsigned i = 0; i < WIN; i++) mem[i] <= '0;
        end else if (wr_fire && in_window) begin
            mem[ptr[REG_AW-1:0]] <= rx_byte;
        end
    end

endmodule

// File: tb/tb_sccb_target_model.sv
// Bench for sccb_target_model: bit-banged SCCB initiator, byte-level model of
// the register map and pointer, and a strobe monitor checked every cycle.
module tb_sccb_target_model;

    localparam int Q = 4;

    logic        clk = 1'b0;
    logic        rest_n = 1'b0;
    logic        m_scl = 1'b1;
    logic        m_sda_low = 1'b0;
    wire         sda_bus;
    logic        reg_wr_valid;
    logic [15:0] reg_wr_addr;
    logic [7:0]  reg_wr_data;
    logic        busy;

    assign sda_bus = m_sda_low ? 1'b0 : 1'bz;
    pullup (sda_bus);

    always #5 clk = ~clk;

    sccb_target_model #(
        .DEVICE_ADDR(8'h78),
        .REG_BASE(16'h3100),
        .REG_AW(4),
        .ID_HI(8'h56),
        .ID_LO(8'h40)
    ) dut (
        .clk(clk),
        .rest_n(rest_n),
        .sccb_scl(m_scl),
        .sccb_sda(sda_bus),
        .reg_wr_valid(reg_wr_valid),
        .reg_wr_addr(reg_wr_addr),
        .reg_wr_data(reg_wr_data),
        .busy(busy)
    );

    int          n_chk = 0;
    int          n_pass = 0;
    int          strobe_cnt = 0;
    logic [15:0] last_addr = '0;
    logic [7:0]  last_data = '0;
    logic [23:0] exp_q[$];

    // Reference model: 16-byte window at 3100, IDs, auto-incrementing pointer.
    logic [7:0]  mdl_mem [16];
    logic [15:0] mdl_ptr;
    logic [7:0]  rd_buf [3];

    function automatic logic [7:0] mdl_read(input logic [15:0] a);
        if (a >= 16'h3100 && a <= 16'h310F) return mdl_mem[a - 16'h3100];
        if (a == 16'h300A) return 8'h56;
        if (a == 16'h300B) return 8'h40;
        return 8'h00;
    endfunction

    task automatic mdl_reset();
        for (int i = 0; i < 16; i++) mdl_mem[i] = 8'h00;
        mdl_ptr = 16'h0000;
        exp_q.delete();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Strobe monitor: every pulse must match the next expected (addr,data).
    always @(negedge clk) begin
        if (rest_n && reg_wr_valid) begin
            n_chk++;
            strobe_cnt++;
            last_addr = reg_wr_addr;
            last_data = reg_wr_data;
            if (exp_q.size() == 0) begin
                $display("FAIL strobe_unexpected: got addr=%h data=%h expected no strobe",
                         reg_wr_addr, reg_wr_data);
            end else begin
                logic [23:0] e;
                e = exp_q.pop_front();
                if ({reg_wr_addr, reg_wr_data} === e) n_pass++;
                else $display("FAIL strobe: got addr=%h data=%h expected addr=%h data=%h",
                              reg_wr_addr, reg_wr_data, e[23:8], e[7:0]);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic qwait();
        repeat (Q) @(posedge clk);
        #1;
    endtask

    task automatic bus_start();
        qwait(); m_sda_low = 1'b0;
        qwait(); m_scl = 1'b1;
        qwait(); m_sda_low = 1'b1;
        qwait(); m_scl = 1'b0;
    endtask

    task automatic bus_stop();
        qwait(); m_sda_low = 1'b1;
        qwait(); m_scl = 1'b1;
        qwait(); m_sda_low = 1'b0;
        qwait();
    endtask

    task automatic bit_cycle(input logic b, output logic r);
        qwait(); m_sda_low = ~b;
        qwait(); m_scl = 1'b1;
        qwait(); r = sda_bus;
        qwait(); m_scl = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, output logic acked);
        logic r;
        for (int i = 7; i >= 0; i--) bit_cycle(d[i], r);
        bit_cycle(1'b1, r);
        acked = ~r;
    endtask

    task automatic recv_byte(input logic nack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bit_cycle(1'b1, r);
            d[i] = r;
        end
        bit_cycle(nack, r);
    endtask

    task automatic do_write(input logic [7:0] dev, input logic [15:0] addr,
                            input logic [23:0] data, input int n);
        logic       ack;
        logic [7:0] b;
        logic [23:0] d;
        bus_start();
        check("busy_in_txn", busy, 1'b1);
        send_byte(dev, ack);
        check("dev_ack", ack, dev[7:1] == 7'h3C);
        if (dev[7:1] != 7'h3C) begin
            bus_stop();
            check("busy_after_stop", busy, 1'b0);
            return;
        end
        send_byte(addr[15:8], ack); check("sub_hi_ack", ack, 1'b1);
        send_byte(addr[7:0], ack);  check("sub_lo_ack", ack, 1'b1);
        mdl_ptr = addr;
        d = data;
        for (int k = 0; k < n; k++) begin
            b = d[23:16];
            d = d << 8;
            exp_q.push_back({mdl_ptr, b});
            if (mdl_ptr >= 16'h3100 && mdl_ptr <= 16'h310F) mdl_mem[mdl_ptr - 16'h3100] = b;
            mdl_ptr = mdl_ptr + 16'd1;
            send_byte(b, ack);
            check("data_ack", ack, 1'b1);
        end
        bus_stop();
    endtask

    task automatic do_read(input logic [15:0] addr, input int n, input logic use_stop);
        logic       ack;
        logic [7:0] d;
        bus_start();
        send_byte(8'h78, ack);      check("rd_dev_w_ack", ack, 1'b1);
        send_byte(addr[15:8], ack); check("rd_hi_ack", ack, 1'b1);
        send_byte(addr[7:0], ack);  check("rd_lo_ack", ack, 1'b1);
        mdl_ptr = addr;
        if (use_stop) bus_stop();
        bus_start();
        send_byte(8'h79, ack);      check("rd_dev_r_ack", ack, 1'b1);
        for (int k = 0; k < n; k++) begin
            recv_byte(k == n - 1, d);
            rd_buf[k] = d;
            check("rd_data", d, mdl_read(mdl_ptr));
            if (k != n - 1) mdl_ptr = mdl_ptr + 16'd1;
        end
        bus_stop();
    endtask

    initial begin
        int          s0;
        logic        r;
        logic [7:0]  dev;
        logic [15:0] a;
        logic [23:0] dat;
        logic [7:0]  bits78;

        mdl_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", reg_wr_valid, 1'b0);
        check("rst_addr", reg_wr_addr, 16'h0000);
        check("rst_data", reg_wr_data, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_sda", sda_bus, 1'b1);
        rest_n = 1'b1;
        qwait();

        // Single write, reported once on the strobe.
        s0 = strobe_cnt;
        do_write(8'h78, 16'h3105, 24'hA5_0000, 1);
        qwait();
        check("t1_strobes", strobe_cnt - s0, 1);
        check("t1_addr", last_addr, 16'h3105);
        check("t1_data", last_data, 8'hA5);

        // Chip-ID reads with STOP between pointer set and read.
        do_read(16'h300A, 1, 1'b1);
        check("t2_id_hi", rd_buf[0], 8'h56);
        do_read(16'h300B, 1, 1'b1);
        check("t2_id_lo", rd_buf[0], 8'h40);

        // Burst write then burst read over a repeated start.
        do_write(8'h78, 16'h3100, 24'h112233, 3);
        do_read(16'h3100, 3, 1'b0);
        check("t3_b0", rd_buf[0], 8'h11);
        check("t3_b1", rd_buf[1], 8'h22);
        check("t3_b2", rd_buf[2], 8'h33);

        // Foreign device address: no ACK, no strobe, busy drops at STOP.
        s0 = strobe_cnt;
        do_write(8'h42, 16'h3104, 24'h770000, 1);
        check("t4_strobes", strobe_cnt - s0, 0);

        // STOP after four data bits aborts the byte.
        s0 = strobe_cnt;
        bus_start();
        send_byte(8'h78, r); check("t5_dev_ack", r, 1'b1);
        send_byte(8'h31, r); check("t5_hi_ack", r, 1'b1);
        send_byte(8'h07, r); check("t5_lo_ack", r, 1'b1);
        mdl_ptr = 16'h3107;
        for (int i = 0; i < 4; i++) bit_cycle(i[0], r);
        bus_stop();
        check("t5_strobes", strobe_cnt - s0, 0);
        do_read(16'h3107, 1, 1'b1);
        check("t5_readback", rd_buf[0], 8'h00);

        // Reset while the target drives the address ACK.
        bus_start();
        bits78 = 8'h78;
        for (int i = 7; i >= 0; i--) bit_cycle(bits78[i], r);
        qwait(); m_sda_low = 1'b0;
        qwait();
        check("t6_ack_drive", sda_bus, 1'b0);
        rest_n = 1'b0;
        #1;
        check("t6_sda_released", sda_bus, 1'b1);
        check("t6_busy", busy, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rest_n = 1'b1;
        mdl_reset();
        bus_stop();
        do_write(8'h78, 16'h3101, 24'h5A0000, 1);
        do_read(16'h3101, 1, 1'b1);
        check("t6_readback", rd_buf[0], 8'h5A);
        do_read(16'h3100, 1, 1'b1);
        check("t6_cleared", rd_buf[0], 8'h00);

        // Randomised transactions against the model.
        for (int t = 0; t < 20; t++) begin
            case ($urandom_range(0, 5))
                0, 1, 2: a = 16'h3100 + 16'($urandom_range(0, 15));
                3:       a = ($urandom_range(0, 1) != 0) ? 16'h300B : 16'h300A;
                4:       a = 16'hFFFF;
                default: a = 16'($urandom());
            endcase
            dat = 24'($urandom());
            case ($urandom_range(0, 3))
                0, 1: do_write(8'h78, a, dat, int'($urandom_range(1, 3)));
                2:    do_read(a, int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)));
                default: begin
                    dev = 8'($urandom());
                    if (dev[7:1] == 7'h3C) dev = dev ^ 8'h02;
                    do_write(dev, a, dat, 1);
                end
            endcase
        end

        qwait();
        check("strobes_outstanding", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
